// File: rtl/srp_pkg.sv
// Shared constants and FSM state type for the sample-buffer readout path.
package srp_pkg;

  localparam int unsigned SRP_BUF_DEPTH = 2240;
  localparam int unsigned SRP_ADDR_W    = 12;
  localparam int unsigned SRP_DATA_W    = 8;
  localparam int unsigned SRP_LEN_W     = 12;

  typedef enum logic [1:0] {
    SRP_IDLE  = 2'd0,
    SRP_READ  = 2'd1,
    SRP_DRAIN = 2'd2
  } srp_state_e;

endpackage

// File: rtl/srp_skid_buf.sv
// Two-entry FIFO between the buffer read port and the stream output.
module srp_skid_buf #(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic         wr_q;
  logic         rd_q;
  logic [1:0]   cnt_q;
  logic         push_c;
  logic         pop_c;

  assign pop_c  = (cnt_q != 2'd0) && out_ready;
  // A full FIFO still accepts when it is popping in the same cycle
  assign push_c = in_valid && ((cnt_q != 2'd2) || pop_c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_c) begin
        mem_q[wr_q] <= in_data;
        wr_q        <= ~wr_q;
      end
      if (pop_c) begin
        rd_q <= ~rd_q;
      end
      cnt_q <= cnt_q + 2'(push_c) - 2'(pop_c);
    end
  end

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = mem_q[rd_q];
  assign count     = cnt_q;

endmodule

// File: rtl/srp_buff_readout.sv
// Reads a frame out of the circular sample buffer and streams it on valid/ready.
module srp_buff_readout
  import srp_pkg::*;
#(
  parameter int unsigned DEPTH  = SRP_BUF_DEPTH,
  parameter int unsigned ADDR_W = SRP_ADDR_W,
  parameter int unsigned DATA_W = SRP_DATA_W,
  parameter int unsigned LEN_W  = SRP_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  frame_len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  srp_state_e        state_q, state_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  issued_q, issued_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              rd_vld_q;
  logic              rd_last_q;

  logic              issue_c;
  logic              last_issue_c;
  logic              pop_c;
  logic [2:0]        occ_c;
  logic              skid_vld;
  logic [DATA_W:0]   skid_data;
  logic [1:0]        skid_cnt;

  // Credit counts the read landing this cycle plus stored samples, net of the pop
  assign pop_c        = skid_vld && m_ready;
  assign occ_c        = 3'(skid_cnt) + 3'(rd_vld_q) - 3'(pop_c);
  assign last_issue_c = (issued_q == (len_q - LEN_W'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SRP_IDLE;
      rd_ptr_q  <= '0;
      len_q     <= '0;
      issued_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_ptr_q  <= rd_ptr_d;
      len_q     <= len_d;
      issued_q  <= issued_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rd_vld_q  <= issue_c;
      rd_last_q <= issue_c && last_issue_c;
    end
  end

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    len_d    = len_q;
    issued_d = issued_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    issue_c  = 1'b0;
    case (state_q)
      SRP_IDLE: begin
        if (start) begin
          if ((start_addr >= ADDR_W'(DEPTH)) || (frame_len > LEN_W'(DEPTH))) begin
            err_d = 1'b1;
          end else if (frame_len == '0) begin
            done_d = 1'b1;
          end else begin
            rd_ptr_d = start_addr;
            len_d    = frame_len;
            issued_d = '0;
            busy_d   = 1'b1;
            state_d  = SRP_READ;
          end
        end
      end
      SRP_READ: begin
        issue_c = (occ_c < 3'd2);
        if (issue_c) begin
          rd_ptr_d = (rd_ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + ADDR_W'(1);
          issued_d = issued_q + LEN_W'(1);
          if (last_issue_c) begin
            state_d = SRP_DRAIN;
          end
        end
      end
      SRP_DRAIN: begin
        if (pop_c && m_last) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = SRP_IDLE;
        end
      end
      default: begin
        state_d = SRP_IDLE;
      end
    endcase
  end

  srp_skid_buf #(
    .W(DATA_W + 1)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_vld_q),
    .in_data   ({rd_last_q, bram_dout}),
    .out_valid (skid_vld),
    .out_ready (m_ready),
    .out_data  (skid_data),
    .count     (skid_cnt)
  );

  assign bram_en   = issue_c;
  assign bram_we   = 1'b0;
  assign bram_addr = rd_ptr_q;
  assign m_valid   = skid_vld;
  assign m_data    = skid_data[DATA_W-1:0];
  assign m_last    = skid_data[DATA_W];
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_srp_buff_readout.sv
// Self-checking bench for srp_buff_readout: vector table, reset abort and random frames.
module tb_srp_buff_readout;

  localparam int DEPTH = 2240;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [11:0] start_addr = '0;
  logic [11:0] frame_len = '0;
  logic        busy, done, err;
  logic        bram_en, bram_we;
  logic [11:0] bram_addr;
  logic [7:0]  bram_dout;
  logic        m_valid, m_last;
  logic        m_ready = 1'b0;
  logic [7:0]  m_data;

  typedef struct {
    int         cyc;
    logic       last;
    logic [7:0] data;
  } beat_t;

  typedef struct {
    string tag;
    int    addr;
    int    len;
    int    mode;     // 0 ready high, 1 pattern 1,0,0,1, 2 random
    bit    inj;      // extra start requests while busy
    bit    exp_err;
    int    e_first;  // cycles from start to first beat, -1 = unchecked
    int    e_last;
    int    e_done;
  } vec_t;

  logic [7:0] ram [DEPTH];
  beat_t      got [$];
  int         cyc = 0;
  int         done_cnt = 0, err_cnt = 0, vcnt = 0, viol = 0;
  int         done_cyc = 0, err_cyc = 0;
  int         ready_mode = 0;
  int         n_total = 0, n_pass = 0;
  bit         hold_q = 1'b0;
  logic [7:0] hold_d = '0;
  logic       hold_l = 1'b0;

  srp_buff_readout dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .frame_len  (frame_len),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .bram_en    (bram_en),
    .bram_we    (bram_we),
    .bram_addr  (bram_addr),
    .bram_dout  (bram_dout),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Buffer model: one-cycle registered read
  always @(posedge clk) begin
    if (bram_en && (bram_addr < 12'(DEPTH))) bram_dout <= ram[bram_addr];
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      2:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
  end

  // Monitor: beats, pulses, port rule violations
  always @(negedge clk) begin
    if (rst) begin
      hold_q = 1'b0;
    end else begin
      if (m_valid) vcnt++;
      if (m_valid && m_ready) got.push_back('{cyc, m_last, m_data});
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (err) begin err_cnt++; err_cyc = cyc; end
      if (bram_we || (bram_en && (bram_addr >= 12'(DEPTH)))) viol++;
      if (hold_q && (!m_valid || (m_data != hold_d) || (m_last != hold_l))) viol++;
      hold_q = m_valid && !m_ready;
      hold_d = m_data;
      hold_l = m_last;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic run_frame(input vec_t v);
    int b0, d0, e0, v0, w0, c0, nexp, nbad, ngap, lim;
    bit fin;
    b0 = got.size(); d0 = done_cnt; e0 = err_cnt; v0 = vcnt; w0 = viol;
    ready_mode = v.mode;
    @(posedge clk); #1;
    start = 1'b1; start_addr = 12'(v.addr); frame_len = 12'(v.len);
    @(negedge clk); c0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    fin = 1'b0;
    lim = 6 * v.len + 40;
    for (int n = 1; n <= lim; n++) begin
      @(negedge clk); #1;
      if (n == 1) chk({v.tag, ":busy"}, int'(busy), (v.exp_err || v.len == 0) ? 0 : 1);
      if (v.inj && n == 2) begin start = 1'b1; start_addr = 12'(DEPTH); frame_len = 12'd4; end
      if (v.inj && n == 3) begin start_addr = 12'd0; frame_len = 12'd5; end
      if (v.inj && n == 4) start = 1'b0;
      if (done_cnt != d0 || err_cnt != e0) begin fin = 1'b1; break; end
    end
    start = 1'b0;
    chk({v.tag, ":finished"}, int'(fin), 1);
    repeat (4) begin @(negedge clk); #1; end
    nexp = v.exp_err ? 0 : v.len;
    chk({v.tag, ":err_pulses"}, err_cnt - e0, v.exp_err ? 1 : 0);
    chk({v.tag, ":done_pulses"}, done_cnt - d0, v.exp_err ? 0 : 1);
    if (v.exp_err) chk({v.tag, ":err_latency"}, err_cyc - c0, 1);
    chk({v.tag, ":beats"}, got.size() - b0, nexp);
    if (nexp == 0) chk({v.tag, ":valid_cycles"}, vcnt - v0, 0);
    nbad = 0; ngap = 0;
    for (int i = 0; i < nexp && (b0 + i) < got.size(); i++) begin
      if (got[b0+i].data != ram[(v.addr + i) % DEPTH] || got[b0+i].last != (i == nexp - 1)) nbad++;
      if (i > 0 && got[b0+i].cyc != got[b0+i-1].cyc + 1) ngap++;
    end
    chk({v.tag, ":data_last"}, nbad, 0);
    if (v.mode == 0) chk({v.tag, ":gaps"}, ngap, 0);
    if (v.e_first >= 0 && got.size() > b0) chk({v.tag, ":first_lat"}, got[b0].cyc - c0, v.e_first);
    if (v.e_last >= 0 && got.size() > b0) chk({v.tag, ":last_lat"}, got[got.size()-1].cyc - c0, v.e_last);
    if (v.e_done >= 0) chk({v.tag, ":done_lat"}, done_cyc - c0, v.e_done);
    chk({v.tag, ":port_rules"}, viol - w0, 0);
    chk({v.tag, ":busy_after"}, int'(busy), 0);
  endtask

  initial begin
    vec_t vecs [10];
    vec_t v;
    int   b0, d0;

    for (int i = 0; i < DEPTH; i++) ram[i] = 8'(i);

    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_state", int'({busy, done, err, bram_en, bram_we, bram_addr, m_valid, m_data, m_last}), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    vecs[0] = '{"basic",        100,  4,    0, 0, 0, 3, 6,    7};
    vecs[1] = '{"wrap",         2238, 4,    0, 0, 0, 3, 6,    7};
    vecs[2] = '{"backpressure", 500,  16,   1, 0, 0, -1, -1,  -1};
    vecs[3] = '{"rej_addr",     2240, 4,    0, 0, 1, -1, -1,  -1};
    vecs[4] = '{"rej_len",      10,   2241, 0, 0, 1, -1, -1,  -1};
    vecs[5] = '{"zero_len",     7,    0,    0, 0, 0, -1, -1,  1};
    vecs[6] = '{"single",       2239, 1,    0, 0, 0, 3, 3,    4};
    vecs[7] = '{"busy_start",   300,  8,    0, 1, 0, 3, 10,   11};
    vecs[8] = '{"max_wrap_rnd", 1000, 2240, 2, 0, 0, -1, -1,  -1};
    vecs[9] = '{"full_depth",   0,    2240, 0, 0, 0, 3, 2242, 2243};
    for (int i = 0; i < 10; i++) run_frame(vecs[i]);

    // Reset in the middle of a 20-beat frame
    ready_mode = 0;
    b0 = got.size(); d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; start_addr = 12'd0; frame_len = 12'd20;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < 100 && (got.size() - b0) < 5; n++) begin @(negedge clk); #1; end
    chk("rst_mid:beats_before", got.size() - b0, 5);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_mid:outputs", int'({busy, done, err, bram_en, bram_we, bram_addr, m_valid, m_data, m_last}), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) begin @(negedge clk); #1; end
    chk("rst_mid:beats_total", got.size() - b0, 5);
    chk("rst_mid:no_done", done_cnt - d0, 0);
    v = '{"post_rst", 0, 2, 0, 0, 0, 3, 4, 5};
    run_frame(v);

    // Random frames against the circular-read model
    for (int i = 0; i < DEPTH; i++) ram[i] = 8'($urandom);
    for (int k = 0; k < 24; k++) begin
      v.tag  = $sformatf("rnd%0d", k);
      v.addr = int'($urandom_range(0, DEPTH - 1));
      v.len  = int'($urandom_range(0, 40));
      if (k % 6 == 5) v.addr = int'($urandom_range(DEPTH, 4095));
      if (k % 8 == 7) v.len = int'($urandom_range(DEPTH - 8, DEPTH + 8));
      v.mode    = 2;
      v.inj     = 1'b0;
      v.exp_err = (v.addr >= DEPTH) || (v.len > DEPTH);
      v.e_first = -1;
      v.e_last  = -1;
      v.e_done  = (!v.exp_err && v.len == 0) ? 1 : -1;
      run_frame(v);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
